// File: rtl/ceyloniac_memory_interface_unit_if.sv
// Request/acknowledge memory port between the interface unit (master)
// and a variable-latency memory (slave).
interface ceyloniac_memory_interface_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/ceyloniac_memory_interface_unit.sv
// Memory interface and IR/MDR capture stage in front of the multi-cycle control
// unit: turns control strobes into one memory transaction and stalls until done.
module ceyloniac_memory_interface_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  i_or_d,
  input  logic                  ir_write,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] write_data,
  ceyloniac_memory_interface_unit_if.master mem,
  output logic                  control_enable,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [5:0]            opcode,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic                  bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_ir_write;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_instruction;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic                  r_bus_error;

  state_t                w_state_next;
  logic                  w_mem_req_next;
  logic                  w_mem_we_next;
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic [DATA_WIDTH-1:0] w_mem_wdata_next;
  logic                  w_ir_write_next;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_instruction_next;
  logic [DATA_WIDTH-1:0] w_mdr_next;
  logic                  w_bus_error_next;
  logic                  w_strobe;
  logic                  w_timeout;

  assign w_strobe  = mem_read | mem_write;
  // Counter holds the number of BUSY cycles already elapsed, so the abort
  // lands on the TIMEOUT_CYCLES-th BUSY cycle.
  assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next       = r_state;
    w_mem_req_next     = r_mem_req;
    w_mem_we_next      = r_mem_we;
    w_mem_addr_next    = r_mem_addr;
    w_mem_wdata_next   = r_mem_wdata;
    w_ir_write_next    = r_ir_write;
    w_count_next       = r_count;
    w_instruction_next = r_instruction;
    w_mdr_next         = r_mdr;
    w_bus_error_next   = r_bus_error;

    case (r_state)
      IDLE: begin
        if (w_strobe) begin
          w_mem_addr_next  = i_or_d ? alu_out : pc;
          w_mem_wdata_next = write_data;
          w_mem_we_next    = mem_write;
          w_ir_write_next  = ir_write;
          w_mem_req_next   = 1'b1;
          w_count_next     = '0;
          w_state_next     = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          w_mem_req_next = 1'b0;
          // A write (including read+write together) never loads IR or MDR.
          if (!r_mem_we) begin
            w_mdr_next = mem.mem_rdata;
            if (r_ir_write) begin
              w_instruction_next = mem.mem_rdata;
            end
          end
          w_state_next = DONE;
        end else if (w_timeout) begin
          w_mem_req_next   = 1'b0;
          w_bus_error_next = 1'b1;
          w_state_next     = DONE;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_ir_write    <= 1'b0;
      r_count       <= '0;
      r_instruction <= '0;
      r_mdr         <= '0;
      r_bus_error   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_mem_req     <= w_mem_req_next;
      r_mem_we      <= w_mem_we_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_ir_write    <= w_ir_write_next;
      r_count       <= w_count_next;
      r_instruction <= w_instruction_next;
      r_mdr         <= w_mdr_next;
      r_bus_error   <= w_bus_error_next;
    end
  end

  // Stall the control unit from the launching IDLE cycle until DONE.
  assign control_enable = ((r_state == IDLE) && !w_strobe) || (r_state == DONE);

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  assign instruction = r_instruction;
  assign opcode      = r_instruction[31:26];
  assign mdr         = r_mdr;
  assign bus_error   = r_bus_error;

endmodule

// File: tb/tb_ceyloniac_memory_interface_unit.sv
// Directed bench for the memory interface unit: fetch, delayed store, timeout,
// simultaneous strobes, spurious ack and reset during an access.
`timescale 1ns/1ps
module tb_ceyloniac_memory_interface_unit;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read, mem_write, i_or_d, ir_write;
  logic [AW-1:0] pc, alu_out;
  logic [DW-1:0] write_data;
  logic          control_enable;
  logic [DW-1:0] instruction, mdr;
  logic [5:0]    opcode;
  logic          bus_error;

  int n_checks = 0;
  int n_pass   = 0;

  ceyloniac_memory_interface_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

  ceyloniac_memory_interface_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc(pc), .alu_out(alu_out), .write_data(write_data),
    .mem(mem_bus),
    .control_enable(control_enable), .instruction(instruction), .opcode(opcode),
    .mdr(mdr), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; i_or_d = 1'b0; ir_write = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    pc = '0; alu_out = '0; write_data = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    // Reset with no strobes
    reset = 1'b1;
    #2;
    chk("rst_ce_during", control_enable, 1);
    chk("rst_req_during", mem_bus.mem_req, 0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_we", mem_bus.mem_we, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_wdata", mem_bus.mem_wdata, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_berr", bus_error, 0);
    chk("rst_ce", control_enable, 1);
    step();
    chk("rst_idle_ce", control_enable, 1);
    chk("rst_idle_req", mem_bus.mem_req, 0);
    $display("txn reset: done");

    // Instruction fetch, zero-wait
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b0; pc = 32'h40; alu_out = 32'h999;
    #1;
    chk("fetch_c0_ce", control_enable, 0);
    step();
    chk("fetch_c1_req", mem_bus.mem_req, 1);
    chk("fetch_c1_we", mem_bus.mem_we, 0);
    chk("fetch_c1_addr", mem_bus.mem_addr, 32'h40);
    chk("fetch_c1_ce", control_enable, 0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h4400_0000;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("fetch_c2_req", mem_bus.mem_req, 0);
    chk("fetch_c2_ce", control_enable, 1);
    chk("fetch_instr", instruction, 32'h4400_0000);
    chk("fetch_opcode", opcode, 6'b010001);
    chk("fetch_mdr", mdr, 32'h4400_0000);
    idle_inputs();
    step();
    chk("fetch_after_req", mem_bus.mem_req, 0);
    $display("txn fetch: addr=0x40 instr=0x%08h", instruction);

    // Store with ack on the 3rd BUSY cycle
    mem_write = 1'b1; i_or_d = 1'b1; alu_out = 32'h100; pc = 32'h44; write_data = 32'hDEAD_BEEF;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("store_c%0d_req", k), mem_bus.mem_req, 1);
      chk($sformatf("store_c%0d_we", k), mem_bus.mem_we, 1);
      chk($sformatf("store_c%0d_addr", k), mem_bus.mem_addr, 32'h100);
      chk($sformatf("store_c%0d_wdata", k), mem_bus.mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("store_c%0d_ce", k), control_enable, 0);
      write_data = 32'h0BAD_0BAD;
      alu_out    = 32'h0BAD;
    end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("store_done_ce", control_enable, 1);
    chk("store_done_req", mem_bus.mem_req, 0);
    chk("store_instr_keep", instruction, 32'h4400_0000);
    chk("store_mdr_keep", mdr, 32'h4400_0000);
    idle_inputs();
    step();
    $display("txn store: addr=0x100 data=0xdeadbeef");

    // Timeout with no ack
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b0; pc = 32'h80;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("tmo_c%0d_req", k), mem_bus.mem_req, 1);
      chk($sformatf("tmo_c%0d_berr", k), bus_error, 0);
    end
    step();
    chk("tmo_done_req", mem_bus.mem_req, 0);
    chk("tmo_done_berr", bus_error, 1);
    chk("tmo_done_ce", control_enable, 1);
    chk("tmo_instr_keep", instruction, 32'h4400_0000);
    chk("tmo_mdr_keep", mdr, 32'h4400_0000);
    idle_inputs();
    step(); step();
    chk("tmo_berr_sticky", bus_error, 1);
    $display("txn timeout: addr=0x80 bus_error=%0b", bus_error);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("tmo_berr_cleared", bus_error, 0);
    step();

    // Ack on the 4th BUSY cycle beats the timeout
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b0; pc = 32'h84;
    step(); step(); step(); step();
    chk("edge_c4_req", mem_bus.mem_req, 1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hA800_0123;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("edge_berr", bus_error, 0);
    chk("edge_instr", instruction, 32'hA800_0123);
    chk("edge_opcode", opcode, 6'b101010);
    chk("edge_mdr", mdr, 32'hA800_0123);
    chk("edge_ce", control_enable, 1);
    idle_inputs();
    step();
    $display("txn late ack: instr=0x%08h", instruction);

    // Read and write together: write wins, single transaction
    mem_read = 1'b1; mem_write = 1'b1; ir_write = 1'b1; i_or_d = 1'b1;
    alu_out = 32'h200; write_data = 32'hCAFE_F00D;
    step();
    chk("both_req", mem_bus.mem_req, 1);
    chk("both_we", mem_bus.mem_we, 1);
    chk("both_addr", mem_bus.mem_addr, 32'h200);
    chk("both_wdata", mem_bus.mem_wdata, 32'hCAFE_F00D);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h5555_5555;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("both_done_ce", control_enable, 1);
    chk("both_instr_keep", instruction, 32'hA800_0123);
    chk("both_mdr_keep", mdr, 32'hA800_0123);
    step();
    chk("both_no_relaunch", mem_bus.mem_req, 0);
    idle_inputs();
    #1;
    chk("both_idle_ce", control_enable, 1);
    step();
    $display("txn read+write: addr=0x200 we=1");

    // Spurious ack in IDLE
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("spur_req", mem_bus.mem_req, 0);
    chk("spur_mdr", mdr, 32'hA800_0123);
    chk("spur_instr", instruction, 32'hA800_0123);
    chk("spur_ce", control_enable, 1);
    step();
    $display("txn spurious ack: ignored");

    // Reset in the 2nd BUSY cycle
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b0; pc = 32'h300;
    step();
    chk("rmid_c1_req", mem_bus.mem_req, 1);
    step();
    chk("rmid_c2_req", mem_bus.mem_req, 1);
    reset = 1'b1;
    #1;
    chk("rmid_req_drop", mem_bus.mem_req, 0);
    idle_inputs();
    #1;
    chk("rmid_ce_idle", control_enable, 1);
    step();
    reset = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h7777_7777;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("rmid_late_req", mem_bus.mem_req, 0);
    chk("rmid_late_mdr", mdr, 0);
    chk("rmid_late_instr", instruction, 0);
    chk("rmid_late_ce", control_enable, 1);
    $display("txn reset mid-access: addr=0x300 aborted");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
